// File: rtl/alu_tile_pkg.sv
// Shared types and constants for the ALU tile arbiter slice.
package alu_tile_pkg;

  localparam int OP_W   = 4;
  localparam int OPND_W = 8;
  localparam int RES_W  = 16;
  localparam int WORD_W = 32;
  localparam int OP_MSB = 31;
  localparam int OP_LSB = 28;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic [OP_W-1:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_MUL   = 4'd2,
    OP_DIV   = 4'd3,
    OP_MOD   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_NOT_A = 4'd8,
    OP_NOT_B = 4'd9,
    OP_SHL_A = 4'd10,
    OP_SHR_A = 4'd11,
    OP_ASR_A = 4'd12,
    OP_SHL_B = 4'd13,
    OP_SHR_B = 4'd14,
    OP_ASR_B = 4'd15
  } opcode_e;

  // Tile register A carries the opcode in its top nibble and operand a in the low byte.
  function automatic logic [WORD_W-1:0] pack_a(input logic [OP_W-1:0] op,
                                               input logic [OPND_W-1:0] a);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OP_MSB:OP_LSB] = op;
    w[OPND_W-1:0] = a;
    return w;
  endfunction

  // Tile register B carries operand b zero-extended.
  function automatic logic [WORD_W-1:0] pack_b(input logic [OPND_W-1:0] b);
    logic [WORD_W-1:0] w;
    w = '0;
    w[OPND_W-1:0] = b;
    return w;
  endfunction

endpackage

// File: rtl/alu_tile_arbiter_if.sv
// Requester/response handshake bundle between two clients and the arbiter.
interface alu_tile_arbiter_if;
  import alu_tile_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [OPND_W-1:0] req0_a;
  logic [OPND_W-1:0] req0_b;
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [OPND_W-1:0] req1_a;
  logic [OPND_W-1:0] req1_b;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [RES_W-1:0]  rsp0_data;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [RES_W-1:0]  rsp1_data;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp1_valid, rsp1_data
  );

endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant: a lone requester always wins, ties go to the pointer.
module rr_arbiter_2 (
  input  logic clk,
  input  logic arst_n,
  input  logic req0,
  input  logic req1,
  input  logic enable,
  input  logic accept,
  output logic gnt_valid,
  output logic gnt_id
);

  logic ptr_q;
  logic ptr_d;

  // Choose the winner and hand priority to the other side once a grant is taken.
  always_comb begin
    gnt_valid = enable & (req0 | req1);
    if (req0 & ~req1) begin
      gnt_id = 1'b0;
    end else if (req1 & ~req0) begin
      gnt_id = 1'b1;
    end else begin
      gnt_id = ptr_q;
    end
    ptr_d = ptr_q;
    if (accept) begin
      ptr_d = ~gnt_id;
    end
  end

  // Priority pointer starts at requester 0.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ptr_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/alu_tile_arbiter.sv
// Shares one fixed-latency ALU tile between two requesters, one operation at a time.
module alu_tile_arbiter
  import alu_tile_pkg::*;
#(
  parameter int ALU_LATENCY = 1
) (
  input  logic              clk,
  input  logic              arst_n,
  alu_tile_arbiter_if.slave bus,
  output logic [WORD_W-1:0] alu_a_o,
  output logic [WORD_W-1:0] alu_b_o,
  input  logic [WORD_W-1:0] alu_c_i,
  output logic              busy,
  output logic              grant_id
);

  localparam logic [2:0] LAST_CNT = 3'(ALU_LATENCY);

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              gid_q, gid_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [RES_W-1:0]  rsp0_data_q, rsp0_data_d;
  logic [RES_W-1:0]  rsp1_data_q, rsp1_data_d;

  logic gnt_valid;
  logic gnt_id;
  logic accept;
  logic rsp_taken;
  logic unused_c_hi;

  assign unused_c_hi = ^alu_c_i[WORD_W-1:RES_W];

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .arst_n    (arst_n),
    .req0      (bus.req0_valid),
    .req1      (bus.req1_valid),
    .enable    (state_q == ST_IDLE),
    .accept    (accept),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Ready only reaches the winner, and only while idle; acceptance is the usual valid&&ready.
  always_comb begin
    bus.req0_ready = gnt_valid & ~gnt_id;
    bus.req1_ready = gnt_valid & gnt_id;
    accept = (bus.req0_valid & bus.req0_ready) | (bus.req1_valid & bus.req1_ready);
    rsp_taken = gid_q ? bus.rsp1_ready : bus.rsp0_ready;
  end

  // Operation sequencing: latch operands, wait out the tile latency, then hold the result.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    gid_d        = gid_q;
    a_d          = a_q;
    b_d          = b_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          gid_d   = gnt_id;
          a_d     = gnt_id ? pack_a(bus.req1_op, bus.req1_a) : pack_a(bus.req0_op, bus.req0_a);
          b_d     = gnt_id ? pack_b(bus.req1_b) : pack_b(bus.req0_b);
          cnt_d   = 3'd0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAST_CNT) begin
          cnt_d   = 3'd0;
          state_d = ST_RESP;
          if (gid_q) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_c_i[RES_W-1:0];
          end else begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_c_i[RES_W-1:0];
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_RESP: begin
        if (rsp_taken) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 3'd0;
      gid_q        <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp1_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gid_q        <= gid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
    end
  end

  assign alu_a_o        = a_q;
  assign alu_b_o        = b_q;
  assign busy           = (state_q != ST_IDLE);
  assign grant_id       = gid_q;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp0_data  = rsp0_data_q;
  assign bus.rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_alu_tile_arbiter.sv
// Self-checking bench for alu_tile_arbiter with a behavioural ALU tile and a timestamp model.
module tb_alu_tile_arbiter;
  import alu_tile_pkg::*;

  localparam int LAT = 1;

  logic        clk = 1'b0;
  logic        arst_n = 1'b1;
  logic [31:0] alu_a_o;
  logic [31:0] alu_b_o;
  logic [31:0] alu_c_i;
  logic        busy;
  logic        grant_id;

  int n_cmp = 0;
  int n_err = 0;

  alu_tile_arbiter_if bus();

  alu_tile_arbiter #(.ALU_LATENCY(LAT)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .bus      (bus),
    .alu_a_o  (alu_a_o),
    .alu_b_o  (alu_b_o),
    .alu_c_i  (alu_c_i),
    .busy     (busy),
    .grant_id (grant_id)
  );

  always #5 clk = ~clk;

  // What the ALU tile computes for each opcode.
  function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
    logic [15:0] za, zb;
    logic signed [15:0] sa, sb;
    za = {8'h00, a};
    zb = {8'h00, b};
    sa = {{8{a[7]}}, a};
    sb = {{8{b[7]}}, b};
    case (op)
      4'd0:  return za + zb;
      4'd1:  return za - zb;
      4'd2:  return za * zb;
      4'd3:  return (b == 8'd0) ? 16'hFFFF : za / zb;
      4'd4:  return (b == 8'd0) ? za : za % zb;
      4'd5:  return za & zb;
      4'd6:  return za | zb;
      4'd7:  return za ^ zb;
      4'd8:  return {8'h00, ~a};
      4'd9:  return {8'h00, ~b};
      4'd10: return za << b[2:0];
      4'd11: return za >> b[2:0];
      4'd12: return 16'(sa >>> b[2:0]);
      4'd13: return zb << a[2:0];
      4'd14: return zb >> a[2:0];
      default: return 16'(sb >>> a[2:0]);
    endcase
  endfunction

  // ALU tile stand-in: result appears LAT edges after the operands, upper half is junk.
  logic [15:0] alu_pipe [LAT];
  always @(posedge clk) begin
    alu_pipe[0] <= alu_ref(alu_a_o[31:28], alu_a_o[7:0], alu_b_o[7:0]);
    for (int i = 1; i < LAT; i++) alu_pipe[i] <= alu_pipe[i-1];
  end
  assign alu_c_i = {16'hA5A5, alu_pipe[LAT-1]};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // No requester may see ready while an operation is in flight.
  always @(negedge clk) begin
    #2;
    check("ready_while_busy", {31'd0, busy & (bus.req0_ready | bus.req1_ready)}, 32'd0);
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic set_req(input int id, input logic v, input logic [3:0] op,
                         input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
  endtask

  function automatic logic get_ready(input int id);
    return (id == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction
  function automatic logic get_rsp_valid(input int id);
    return (id == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction
  function automatic logic [15:0] get_rsp_data(input int id);
    return (id == 0) ? bus.rsp0_data : bus.rsp1_data;
  endfunction

  task automatic check_reset_values();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant_id", {31'd0, grant_id}, 32'd0);
    check("rst_alu_a", alu_a_o, 32'd0);
    check("rst_alu_b", alu_b_o, 32'd0);
    check("rst_rsp0_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
    check("rst_rsp0_data", {16'd0, bus.rsp0_data}, 32'd0);
    check("rst_rsp1_data", {16'd0, bus.rsp1_data}, 32'd0);
  endtask

  // Pulse reset, check the reset state, and release on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    arst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  typedef struct {
    int          id;
    logic [3:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
    logic [15:0] exp_d;
  } vec_t;

  // One isolated operation: grant, operand registers, latency and result.
  task automatic apply_stimulus(input vec_t v);
    int lat;
    lat = 0;
    @(negedge clk);
    set_req(v.id, 1'b1, v.op, v.a, v.b);
    set_req(1 - v.id, 1'b0, 4'd0, 8'd0, 8'd0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check("vec_ready_granted", {31'd0, get_ready(v.id)}, 32'd1);
    check("vec_ready_other", {31'd0, get_ready(1 - v.id)}, 32'd0);
    @(negedge clk);
    set_req(v.id, 1'b0, 4'd0, 8'd0, 8'd0);
    #1;
    check("vec_alu_a", alu_a_o, v.exp_a);
    check("vec_alu_b", alu_b_o, v.exp_b);
    check("vec_grant_id", {31'd0, grant_id}, 32'(v.id));
    check("vec_busy", {31'd0, busy}, 32'd1);
    for (int k = 1; k <= 10 && lat == 0; k++) begin
      @(posedge clk);
      #1;
      if (get_rsp_valid(v.id)) lat = k;
    end
    check("vec_latency", 32'(lat), 32'(LAT + 1));
    check("vec_rsp_data", {16'd0, get_rsp_data(v.id)}, {16'd0, v.exp_d});
    check("vec_other_rsp_valid", {31'd0, get_rsp_valid(1 - v.id)}, 32'd0);
    @(negedge clk);
    if (v.id == 0) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #1;
    check("vec_rsp_cleared", {31'd0, get_rsp_valid(v.id)}, 32'd0);
    check("vec_idle_again", {31'd0, busy}, 32'd0);
  endtask

  // Both requesters stay valid: expect alternating service starting with req0.
  task automatic seq_both();
    int order[$];
    int rsp_id[$];
    logic [15:0] rsp_d[$];
    int first_cyc;
    int exp_ord[4] = '{0, 1, 0, 1};
    logic [15:0] exp_dat[4] = '{16'd12, 16'd42, 16'd12, 16'd42};
    first_cyc = -1;
    do_reset();
    set_req(0, 1'b1, 4'd1, 8'd20, 8'd8);
    set_req(1, 1'b1, 4'd2, 8'd7, 8'd6);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && (order.size() < 4 || rsp_id.size() < 4); cyc++) begin
      #1;
      if (order.size() < 4) begin
        if (bus.req0_ready) begin
          order.push_back(0);
          if (first_cyc < 0) first_cyc = cyc;
        end else if (bus.req1_ready) begin
          order.push_back(1);
        end
      end
      if (bus.rsp0_valid) begin rsp_id.push_back(0); rsp_d.push_back(bus.rsp0_data); end
      if (bus.rsp1_valid) begin rsp_id.push_back(1); rsp_d.push_back(bus.rsp1_data); end
      @(negedge clk);
    end
    check("both_first_accept_cycle", 32'(first_cyc), 32'd0);
    check("both_grant_count", 32'(order.size()), 32'd4);
    check("both_rsp_count", 32'(rsp_id.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check("both_grant_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));
      check("both_rsp_id", (i < rsp_id.size()) ? 32'(rsp_id[i]) : 32'hFFFF_FFFF, 32'(exp_ord[i]));
      check("both_rsp_data", (i < rsp_d.size()) ? {16'd0, rsp_d[i]} : 32'hFFFF_FFFF,
            {16'd0, exp_dat[i]});
    end
    idle_inputs();
  endtask

  // Response held under backpressure while the other requester waits.
  task automatic seq_backpressure();
    logic got;
    got = 1'b0;
    do_reset();
    set_req(0, 1'b1, 4'd3, 8'd40, 8'd5);
    set_req(1, 1'b1, 4'd0, 8'd1, 8'd1);
    #1 check("bp_first_grant_req0", {31'd0, bus.req0_ready}, 32'd1);
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    for (int k = 0; k < 10 && !got; k++) begin
      #1;
      if (bus.rsp0_valid) got = 1'b1;
      else @(negedge clk);
    end
    check("bp_rsp_seen", {31'd0, got}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", {31'd0, bus.rsp0_valid}, 32'd1);
      check("bp_hold_data", {16'd0, bus.rsp0_data}, 32'd8);
      check("bp_req1_ready", {31'd0, bus.req1_ready}, 32'd0);
      check("bp_busy", {31'd0, busy}, 32'd1);
      check("bp_rsp1_valid", {31'd0, bus.rsp1_valid}, 32'd0);
      @(negedge clk);
      #1;
    end
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    bus.rsp0_ready = 1'b0;
    #1;
    check("bp_released_valid", {31'd0, bus.rsp0_valid}, 32'd0);
    check("bp_released_busy", {31'd0, busy}, 32'd0);
    check("bp_req1_now_ready", {31'd0, bus.req1_ready}, 32'd1);
    set_req(1, 1'b0, 4'd0, 8'd0, 8'd0);
    @(negedge clk);
    #1;
    check("withdraw_busy", {31'd0, busy}, 32'd0);
    check("withdraw_grant_id", {31'd0, grant_id}, 32'd0);
    check("withdraw_alu_a", alu_a_o, 32'h3000_0028);
  endtask

  // Reset during WAIT discards the operation; pointer restarts at req0.
  task automatic seq_reset_mid();
    do_reset();
    set_req(0, 1'b1, 4'd0, 8'd1, 8'd2);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 8'd0, 8'd0);
    #1 check("mid_in_wait", {31'd0, busy}, 32'd1);
    #2 arst_n = 1'b0;
    #1 check_reset_values();
    @(negedge clk);
    #1;
    check("mid_no_rsp0", {31'd0, bus.rsp0_valid}, 32'd0);
    check("mid_no_rsp1", {31'd0, bus.rsp1_valid}, 32'd0);
    arst_n = 1'b1;
    set_req(0, 1'b1, 4'd7, 8'hF0, 8'h0F);
    set_req(1, 1'b1, 4'd0, 8'd3, 8'd4);
    #1;
    check("mid_next_ready0", {31'd0, bus.req0_ready}, 32'd1);
    check("mid_next_ready1", {31'd0, bus.req1_ready}, 32'd0);
    @(negedge clk);
    idle_inputs();
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    #1;
    check("mid_next_grant", {31'd0, grant_id}, 32'd0);
    check("mid_xor_alu_a", alu_a_o, 32'h7000_00F0);
    check("mid_xor_alu_b", alu_b_o, 32'h0000_000F);
    for (int k = 0; k < 6; k++) @(negedge clk);
    idle_inputs();
  endtask

  // Random traffic against a timestamp-based transaction model.
  task automatic checkOutput_random(input int cycles);
    logic m_busy, m_gid, m_ptr;
    int m_acc, edge_n;
    logic [3:0] m_op;
    logic [7:0] m_a, m_b;
    logic [31:0] m_alu_a, m_alu_b;
    logic v0, v1, r0, r1, g_valid, g_id, exp_rsp;
    logic [3:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    m_busy = 0; m_gid = 0; m_ptr = 0; m_acc = 0; edge_n = 0;
    m_op = 0; m_a = 0; m_b = 0; m_alu_a = 0; m_alu_b = 0;
    do_reset();
    for (int c = 0; c < cycles; c++) begin
      v0 = ($urandom_range(0, 3) != 0);
      v1 = ($urandom_range(0, 3) != 0);
      r0 = ($urandom_range(0, 2) != 0);
      r1 = ($urandom_range(0, 2) != 0);
      op0 = 4'($urandom); a0 = 8'($urandom); b0 = 8'($urandom);
      op1 = 4'($urandom); a1 = 8'($urandom); b1 = 8'($urandom);
      set_req(0, v0, op0, a0, b0);
      set_req(1, v1, op1, a1, b1);
      bus.rsp0_ready = r0;
      bus.rsp1_ready = r1;
      #1;
      g_valid = !m_busy && (v0 || v1);
      g_id = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : m_ptr;
      exp_rsp = m_busy && (edge_n - m_acc >= LAT + 1);
      check("rnd_ready0", {31'd0, bus.req0_ready}, {31'd0, g_valid && !g_id});
      check("rnd_ready1", {31'd0, bus.req1_ready}, {31'd0, g_valid && g_id});
      check("rnd_rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, exp_rsp && !m_gid});
      check("rnd_rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, exp_rsp && m_gid});
      if (exp_rsp)
        check("rnd_rsp_data", {16'd0, get_rsp_data(int'(m_gid))}, {16'd0, alu_ref(m_op, m_a, m_b)});
      check("rnd_busy", {31'd0, busy}, {31'd0, m_busy});
      check("rnd_grant_id", {31'd0, grant_id}, {31'd0, m_gid});
      check("rnd_alu_a", alu_a_o, m_alu_a);
      check("rnd_alu_b", alu_b_o, m_alu_b);
      @(posedge clk);
      edge_n++;
      if (g_valid) begin
        m_busy = 1'b1;
        m_acc = edge_n;
        m_gid = g_id;
        m_ptr = !g_id;
        m_op = g_id ? op1 : op0;
        m_a = g_id ? a1 : a0;
        m_b = g_id ? b1 : b0;
        m_alu_a = {m_op, 20'd0, m_a};
        m_alu_b = {24'd0, m_b};
      end else if (exp_rsp && (m_gid ? r1 : r0)) begin
        m_busy = 1'b0;
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    vec_t vecs [7];
    vecs[0] = '{0, 4'd0,  8'd10,  8'd5,   32'h0000_000A, 32'h0000_0005, 16'd15};
    vecs[1] = '{1, 4'd7,  8'hF0,  8'h0F,  32'h7000_00F0, 32'h0000_000F, 16'h00FF};
    vecs[2] = '{0, 4'd1,  8'd3,   8'd5,   32'h1000_0003, 32'h0000_0005, 16'hFFFE};
    vecs[3] = '{1, 4'd2,  8'hFF,  8'hFF,  32'h2000_00FF, 32'h0000_00FF, 16'hFE01};
    vecs[4] = '{0, 4'd3,  8'd40,  8'd5,   32'h3000_0028, 32'h0000_0005, 16'd8};
    vecs[5] = '{1, 4'd15, 8'd1,   8'h80,  32'hF000_0001, 32'h0000_0080, 16'hFFC0};
    vecs[6] = '{0, 4'd10, 8'h81,  8'd3,   32'hA000_0081, 32'h0000_0003, 16'h0408};
    idle_inputs();
    do_reset();
    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);
    seq_both();
    seq_backpressure();
    seq_reset_mid();
    checkOutput_random(1500);
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
